// File: rtl/mc_control_fsm.sv
// Multi-cycle main control unit: walks each instruction through FETCH/DECODE/EXEC/MEM/WB
// and drives the shared datapath's control lines, PC write enable and retire counter.
module mc_control_fsm #(
    parameter int          CNT_W   = 32,
    parameter logic [5:0]  HALT_OP = 6'h3F
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [5:0]       OpCode,
    output logic             RegDst,
    output logic             AluSrc,
    output logic             MemtoReg,
    output logic             RegWrite,
    output logic             MemRead,
    output logic             MemWrite,
    output logic             Branch,
    output logic [3:0]       ALUOp,
    output logic             PCWrite,
    output logic             Illegal,
    output logic             Halted,
    output logic [CNT_W-1:0] InstrCount,
    output logic [2:0]       State
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd7
    } state_t;

    localparam logic [5:0] OP_R    = 6'h00;
    localparam logic [5:0] OP_LW   = 6'h23;
    localparam logic [5:0] OP_SW   = 6'h2B;
    localparam logic [5:0] OP_BEQ  = 6'h04;
    localparam logic [5:0] OP_ADDI = 6'h08;

    localparam logic [3:0] ALU_ADD   = 4'b0000;
    localparam logic [3:0] ALU_SUB   = 4'b0001;
    localparam logic [3:0] ALU_FUNCT = 4'b0010;

    state_t     state;
    logic [5:0] op_q;

    function automatic logic is_legal(input logic [5:0] op);
        return (op == OP_R) || (op == OP_LW) || (op == OP_SW) ||
               (op == OP_BEQ) || (op == OP_ADDI);
    endfunction

    // Sequencing, opcode capture, sticky illegal flag and retire counter
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= S_FETCH;
            op_q       <= 6'h00;
            InstrCount <= '0;
            Illegal    <= 1'b0;
        end else begin
            if (PCWrite)
                InstrCount <= InstrCount + CNT_W'(1);
            case (state)
                S_FETCH: state <= S_DECODE;
                S_DECODE: begin
                    op_q <= OpCode;
                    if (OpCode == HALT_OP) begin
                        state <= S_HALT;
                    end else if (is_legal(OpCode)) begin
                        state <= S_EXEC;
                    end else begin
                        state   <= S_HALT;
                        Illegal <= 1'b1;
                    end
                end
                S_EXEC: begin
                    case (op_q)
                        OP_LW, OP_SW:  state <= S_MEM;
                        OP_R, OP_ADDI: state <= S_WB;
                        default:       state <= S_FETCH;
                    endcase
                end
                S_MEM: state <= (op_q == OP_LW) ? S_WB : S_FETCH;
                S_WB:   state <= S_FETCH;
                S_HALT: state <= S_HALT;
                default: state <= S_FETCH;
            endcase
        end
    end

    // Moore decode: depends only on state and the captured opcode, never on OpCode
    always_comb begin
        RegDst   = 1'b0;
        AluSrc   = 1'b0;
        MemtoReg = 1'b0;
        RegWrite = 1'b0;
        MemRead  = 1'b0;
        MemWrite = 1'b0;
        Branch   = 1'b0;
        ALUOp    = ALU_ADD;
        PCWrite  = 1'b0;
        case (state)
            S_EXEC: begin
                case (op_q)
                    OP_R: ALUOp = ALU_FUNCT;
                    OP_ADDI, OP_LW, OP_SW: AluSrc = 1'b1;
                    OP_BEQ: begin
                        ALUOp   = ALU_SUB;
                        Branch  = 1'b1;
                        PCWrite = 1'b1;
                    end
                    default: ;
                endcase
            end
            S_MEM: begin
                AluSrc = 1'b1;
                if (op_q == OP_LW) begin
                    MemRead = 1'b1;
                end else begin
                    MemWrite = 1'b1;
                    PCWrite  = 1'b1;
                end
            end
            S_WB: begin
                RegWrite = 1'b1;
                PCWrite  = 1'b1;
                case (op_q)
                    OP_R: begin
                        RegDst = 1'b1;
                        ALUOp  = ALU_FUNCT;
                    end
                    OP_ADDI: AluSrc = 1'b1;
                    // Read data must stay valid while the register file captures it
                    OP_LW: begin
                        AluSrc   = 1'b1;
                        MemRead  = 1'b1;
                        MemtoReg = 1'b1;
                    end
                    default: ;
                endcase
            end
            default: ;
        endcase
    end

    assign Halted = (state == S_HALT);
    assign State  = state;

endmodule

// File: tb/tb_mc_control_fsm.sv
// Scoreboard bench for mc_control_fsm: stimulus pushes hand-derived per-cycle expectations,
// a monitor pops one per cycle and compares a 32-bit and a 4-bit-counter instance.
module tb_mc_control_fsm;

    logic        clk;
    logic        reset;
    logic [5:0]  OpCode;

    logic        RegDst, AluSrc, MemtoReg, RegWrite, MemRead, MemWrite, Branch, PCWrite;
    logic [3:0]  ALUOp;
    logic        Illegal, Halted;
    logic [31:0] InstrCount;
    logic [2:0]  State;

    logic        RegDst4, AluSrc4, MemtoReg4, RegWrite4, MemRead4, MemWrite4, Branch4, PCWrite4;
    logic [3:0]  ALUOp4;
    logic        Illegal4, Halted4;
    logic [3:0]  InstrCount4;
    logic [2:0]  State4;

    mc_control_fsm #(.CNT_W(32), .HALT_OP(6'h3F)) dut (
        .clk(clk), .reset(reset), .OpCode(OpCode),
        .RegDst(RegDst), .AluSrc(AluSrc), .MemtoReg(MemtoReg), .RegWrite(RegWrite),
        .MemRead(MemRead), .MemWrite(MemWrite), .Branch(Branch), .ALUOp(ALUOp),
        .PCWrite(PCWrite), .Illegal(Illegal), .Halted(Halted),
        .InstrCount(InstrCount), .State(State)
    );

    mc_control_fsm #(.CNT_W(4), .HALT_OP(6'h3F)) dut4 (
        .clk(clk), .reset(reset), .OpCode(OpCode),
        .RegDst(RegDst4), .AluSrc(AluSrc4), .MemtoReg(MemtoReg4), .RegWrite(RegWrite4),
        .MemRead(MemRead4), .MemWrite(MemWrite4), .Branch(Branch4), .ALUOp(ALUOp4),
        .PCWrite(PCWrite4), .Illegal(Illegal4), .Halted(Halted4),
        .InstrCount(InstrCount4), .State(State4)
    );

    typedef struct packed {
        logic [2:0]  st;
        logic [11:0] ctl;
        logic [31:0] cnt;
        logic        ill;
        logic        hlt;
    } exp_t;

    exp_t        q[$];
    event        chk_ev;
    int          total  = 0;
    int          passed = 0;
    int          step_no = 0;
    logic [31:0] exp_cnt = 0;

    // {RegDst,AluSrc,MemtoReg,RegWrite,MemRead,MemWrite,Branch,ALUOp,PCWrite}
    wire [11:0] ctl_v  = {RegDst, AluSrc, MemtoReg, RegWrite, MemRead, MemWrite, Branch, ALUOp, PCWrite};
    wire [11:0] ctl_v4 = {RegDst4, AluSrc4, MemtoReg4, RegWrite4, MemRead4, MemWrite4, Branch4, ALUOp4, PCWrite4};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [11:0] ctl(input logic rd, as, mr, rw, mrd, mw, br,
                                        input logic [3:0] op, input logic pc);
        return {rd, as, mr, rw, mrd, mw, br, op, pc};
    endfunction

    function automatic exp_t mk(input logic [2:0] st, input logic [11:0] c,
                                input logic [31:0] n, input logic ill, input logic hlt);
        exp_t e;
        e.st = st; e.ctl = c; e.cnt = n; e.ill = ill; e.hlt = hlt;
        return e;
    endfunction

    task automatic step(input exp_t e);
        @(posedge clk);
        #1;
        q.push_back(e);
    endtask

    // Leaves the bench in a FETCH cycle with its expectation already queued
    task automatic apply_reset();
        @(posedge clk);
        #1;
        reset   = 1'b1;
        exp_cnt = 0;
        q.push_back(mk(3'd0, 12'h0, 0, 1'b0, 1'b0));
        @(posedge clk);
        #1;
        q.push_back(mk(3'd0, 12'h0, 0, 1'b0, 1'b0));
        reset = 1'b0;
    endtask

    // Starts in a queued FETCH cycle, ends in the next queued FETCH cycle
    task automatic do_instr(input logic [5:0] op);
        OpCode = op;
        step(mk(3'd1, 12'h0, exp_cnt, 1'b0, 1'b0));
        case (op)
            6'h00: begin
                step(mk(3'd2, ctl(0,0,0,0,0,0,0,4'b0010,0), exp_cnt, 1'b0, 1'b0));
                OpCode = ~op;
                step(mk(3'd4, ctl(1,0,0,1,0,0,0,4'b0010,1), exp_cnt, 1'b0, 1'b0));
            end
            6'h08: begin
                step(mk(3'd2, ctl(0,1,0,0,0,0,0,4'b0000,0), exp_cnt, 1'b0, 1'b0));
                OpCode = 6'h2B;
                step(mk(3'd4, ctl(0,1,0,1,0,0,0,4'b0000,1), exp_cnt, 1'b0, 1'b0));
            end
            6'h23: begin
                step(mk(3'd2, ctl(0,1,0,0,0,0,0,4'b0000,0), exp_cnt, 1'b0, 1'b0));
                OpCode = 6'h00;
                step(mk(3'd3, ctl(0,1,0,0,1,0,0,4'b0000,0), exp_cnt, 1'b0, 1'b0));
                step(mk(3'd4, ctl(0,1,1,1,1,0,0,4'b0000,1), exp_cnt, 1'b0, 1'b0));
            end
            6'h2B: begin
                step(mk(3'd2, ctl(0,1,0,0,0,0,0,4'b0000,0), exp_cnt, 1'b0, 1'b0));
                OpCode = 6'h23;
                step(mk(3'd3, ctl(0,1,0,0,0,1,0,4'b0000,1), exp_cnt, 1'b0, 1'b0));
            end
            default: begin
                step(mk(3'd2, ctl(0,0,0,0,0,0,1,4'b0001,1), exp_cnt, 1'b0, 1'b0));
            end
        endcase
        exp_cnt = exp_cnt + 1;
        step(mk(3'd0, 12'h0, exp_cnt, 1'b0, 1'b0));
    endtask

    task automatic do_halt(input logic [5:0] op, input logic ill);
        OpCode = op;
        step(mk(3'd1, 12'h0, exp_cnt, 1'b0, 1'b0));
        for (int i = 0; i < 21; i++) begin
            step(mk(3'd7, 12'h0, exp_cnt, ill, 1'b1));
            OpCode = 6'($urandom_range(0, 63));
        end
    endtask

    // Reset lands while a store is in MEM; MemWrite must fall without waiting for a clock
    task automatic sw_abort();
        OpCode = 6'h2B;
        step(mk(3'd1, 12'h0, exp_cnt, 1'b0, 1'b0));
        step(mk(3'd2, ctl(0,1,0,0,0,0,0,4'b0000,0), exp_cnt, 1'b0, 1'b0));
        step(mk(3'd3, ctl(0,1,0,0,0,1,0,4'b0000,1), exp_cnt, 1'b0, 1'b0));
        @(negedge clk);
        #2;
        reset   = 1'b1;
        exp_cnt = 0;
        #1;
        q.push_back(mk(3'd0, 12'h0, 0, 1'b0, 1'b0));
        ->chk_ev;
        @(posedge clk);
        #1;
        q.push_back(mk(3'd0, 12'h0, 0, 1'b0, 1'b0));
        reset = 1'b0;
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk or chk_ev);
            if (q.size() > 0) begin
                e = q.pop_front();
                step_no++;
                total++;
                if ({State, ctl_v, InstrCount, Illegal, Halted} === {e.st, e.ctl, e.cnt, e.ill, e.hlt})
                    passed++;
                else
                    $display("FAIL cycle%0d dut32: got st=%0d ctl=%03h cnt=%0d ill=%b hlt=%b, required st=%0d ctl=%03h cnt=%0d ill=%b hlt=%b",
                             step_no, State, ctl_v, InstrCount, Illegal, Halted,
                             e.st, e.ctl, e.cnt, e.ill, e.hlt);
                total++;
                if ({State4, ctl_v4, InstrCount4, Illegal4, Halted4} === {e.st, e.ctl, e.cnt[3:0], e.ill, e.hlt})
                    passed++;
                else
                    $display("FAIL cycle%0d dut4: got st=%0d ctl=%03h cnt=%0d ill=%b hlt=%b, required st=%0d ctl=%03h cnt=%0d ill=%b hlt=%b",
                             step_no, State4, ctl_v4, InstrCount4, Illegal4, Halted4,
                             e.st, e.ctl, e.cnt[3:0], e.ill, e.hlt);
            end
        end
    end

    initial begin : stimulus
        reset  = 1'b1;
        OpCode = 6'h00;
        for (int i = 0; i < 3; i++)
            step(mk(3'd0, 12'h0, 0, 1'b0, 1'b0));
        @(posedge clk);
        #1;
        q.push_back(mk(3'd0, 12'h0, 0, 1'b0, 1'b0));
        reset = 1'b0;

        do_instr(6'h00);
        do_instr(6'h23);
        do_instr(6'h2B);
        do_instr(6'h04);

        sw_abort();
        do_instr(6'h2B);

        apply_reset();
        do_instr(6'h08);
        do_instr(6'h08);
        do_halt(6'h3F, 1'b0);

        apply_reset();
        do_halt(6'h12, 1'b1);

        apply_reset();
        for (int i = 0; i < 16; i++)
            do_instr(6'h08);
        do_instr(6'h00);

        for (int i = 0; i < 50 && q.size() > 0; i++)
            @(negedge clk);
        @(negedge clk);
        total++;
        if (q.size() == 0)
            passed++;
        else
            $display("FAIL drain: got %0d queued entries, required 0", q.size());

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/mc_control_fsm.md
Name: mc_control_fsm

Overview:
- Multi-cycle main control unit sitting directly upstream of the datapath.
- Consumes the 6-bit OpCode the datapath exports and sequences each instruction through FETCH/DECODE/EXEC/MEM/WB.
- Drives every datapath control line plus a PC write enable, so a single ALU/memory path serves several cycles per instruction.
- Also provides a retired-instruction counter and illegal/halt status for the testbench and debug.

Parameters:
- CNT_W, 32, width of retired-instruction counter.
- HALT_OP, 6'h3F, opcode that stops the machine cleanly.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- OpCode  in  6  Instruction[31:26] from the datapath.
- RegDst  out  1  1 = write register from rd, 0 = rt.
- AluSrc  out  1  1 = sign-extended immediate to ALU B.
- MemtoReg  out  1  1 = writeback from data memory.
- RegWrite  out  1  register file write enable.
- MemRead  out  1  data memory read enable.
- MemWrite  out  1  data memory write enable.
- Branch  out  1  branch qualifier (ANDed with Zero in datapath).
- ALUOp  out  4  0000 add, 0001 sub, 0010 use funct field.
- PCWrite  out  1  PC advance enable, one pulse per retired instruction.
- Illegal  out  1  sticky: undefined opcode decoded.
- Halted  out  1  high while in HALT.
- InstrCount  out  CNT_W  retired instructions.
- State  out  3  current state: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, HALT=7.

Behaviour:
- Reset (async, any time):
  - State=FETCH, op_q=0, InstrCount=0, Illegal=0.
  - All control outputs 0 while reset is asserted and in the first FETCH.
  - A reset mid-instruction aborts it with no write issued.
- Supported opcodes:
  - R-type 6'h00.
  - lw 6'h23.
  - sw 6'h2B.
  - beq 6'h04.
  - addi 6'h08.
  - HALT_OP.
  - Anything else is illegal.
- Output timing:
  - Outputs are Moore: combinational decode of the state register and op_q only.
  - No combinational path exists from OpCode to any output.
- FETCH:
  - Instruction memory settles; all enables 0.
  - Next state DECODE.
- DECODE:
  - op_q <= OpCode.
  - Next state EXEC for a legal opcode.
  - HALT_OP goes to HALT with Illegal=0.
  - An undefined opcode goes to HALT with Illegal<=1.
  - No enables asserted.
- EXEC:
  - ALUOp: R=0010, addi/lw/sw=0000, beq=0001.
  - AluSrc=1 for addi/lw/sw.
  - beq: Branch=1, PCWrite=1, next FETCH (3 cycles total).
  - R/addi: next WB.
  - lw/sw: next MEM.
- MEM:
  - ALUOp/AluSrc held from EXEC.
  - lw: MemRead=1, next WB.
  - sw: MemWrite=1, PCWrite=1, next FETCH (4 cycles).
- WB:
  - ALUOp/AluSrc held (lw holds MemRead=1 as well so read data stays valid).
  - RegWrite=1, PCWrite=1.
  - RegDst=1 only for R, MemtoReg=1 only for lw.
  - Next FETCH. Totals: R/addi 4 cycles, lw 5 cycles.
- HALT:
  - Absorbing until reset; all enables 0, Halted=1, InstrCount frozen.
- Exclusivity rules:
  - MemWrite and RegWrite are never high in the same cycle.
  - PCWrite is high exactly one cycle per retired instruction.
  - HALT_OP and illegal opcodes do not count as retired.
- InstrCount:
  - Increments on each cycle with PCWrite=1.
  - Wraps to 0 after all-ones with no flag.
- Opcode stability: an OpCode change after DECODE has no effect until the next DECODE, because op_q is held.

Test Plan:
- Reset then OpCode=00 held: State sequence 0,1,2,4,0; in WB RegWrite=1, RegDst=1, ALUOp=0010, PCWrite=1; InstrCount=1 after 4 cycles.
- lw (23): 5-cycle sequence 0,1,2,3,4; MemRead=1 in MEM and WB; WB shows MemtoReg=1, AluSrc=1, RegDst=0; sw (2B): MemWrite=1 only in MEM, RegWrite never 1, 4 cycles.
- beq (04): 3 cycles; Branch=1, ALUOp=0001 and PCWrite=1 only in EXEC; no RegWrite/MemWrite at any point.
- OpCode=3F after two addi: Halted=1, Illegal=0, InstrCount=2 and stays at 2 for 20 further cycles; OpCode=12: Halted=1, Illegal=1.
- Assert reset during MEM of sw: MemWrite drops immediately (async); after release State=0 and InstrCount=0; next sw completes normally.
- CNT_W=4, 16 addi instructions: InstrCount wraps 15->0 with no other side effect.
